sdram_cmd_monitor: RTL and testbench
====================================

// Module: sdram_cmd_monitor
// PURPOSE
//  Synthesizable SDRAM command-bus protocol monitor on sdram_clk; successor to the sim-only SVA checks.
//  Decodes CS/RAS/CAS/WE each cycle and checks, parametrised in bank count and timings:
//  - init sequence
//  - refresh interval
//  - tRCAR, tRP, tRCD per bank
//  - CAS-latency read-data alignment
//  Reports sticky error flags, an error pulse and a saturating error count. Usable in sim and on FPGA.
// PARAMETERS
//  NUM_BANKS   4      banks tracked; BA_W = $clog2(NUM_BANKS)
//  T_INIT_NOP  10000  min NOP/INHIBIT cycles after sdram_en rise
//  INIT_AREF   2      AREFs required during init
//  T_RCAR      7      AREF -> next non-NOP command, min cycles
//  T_RP        2      PRE -> ACT same bank, min cycles
//  T_RCD       2      ACT -> READ/WRITE same bank, min cycles
//  T_RFSH_MAX  256    max cycles between AREFs once running
//  CNT_W       16     timer width (must hold T_INIT_NOP)
//  ERR_CNT_W   8      error counter width
// PORTS
//  sdram_clk     in   1          clock
//  sdram_rst_i   in   1          synchronous active-high reset
//  sdram_en      in   1          controller enable; rise starts init check
//  sdram_cs_n    in   1          chip select
//  sdram_ras_n   in   1          RAS
//  sdram_cas_n   in   1          CAS
//  sdram_we_n    in   1          WE
//  sdram_ba      in   BA_W       bank address
//  sdram_a10     in   1          A10 (PRE-all when 1)
//  cfg_cas_lat   in   3          programmed CAS latency, legal 2 or 3
//  rd_valid      in   1          read data valid on DQ this cycle
//  err_clr       in   1          clears err_flags and err_cnt
//  init_done     out  1          init sequence completed legally
//  err_flags     out  8          sticky error bits, see BEHAVIOUR
//  err_pulse     out  1          1 cycle: any error detected
//  err_cnt       out  ERR_CNT_W  saturating count of error cycles
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; timers 0; bank timers saturated (ready); read pipe cleared.
//  - Decode (RAS,CAS,WE): 111 NOP, 011 ACT, 101 RD, 100 WR, 010 PRE, 001 AREF, 000 MRS, 110 BST.
//    cs_n=1 = INHIBIT, same as NOP.
//  - Latency: command sampled at edge n -> flag/pulse/cnt visible after edge n+1.
//  - Error bits:
//    [0] INIT_SEQ     [1] RFSH_LATE     [2] TRCAR     [3] TRP
//    [4] TRCD         [5] CAS_LAT       [6] CMD_BEFORE_INIT     [7] BAD_CAS_CFG
//  - FSM: IDLE, PWRUP, WAIT_PRE, INIT_AREF, WAIT_MRS, RUN, FAIL.
//    sdram_en low in any state -> IDLE; init_done=0.
//    IDLE   : sdram_en rise -> PWRUP; timer=0.
//    PWRUP  : non-NOP before timer==T_INIT_NOP -> [0], FAIL. Otherwise at count -> WAIT_PRE.
//    WAIT_PRE: PRE with a10=1 -> INIT_AREF; NOP stays; other cmd -> [0], FAIL.
//    INIT_AREF: count AREFs; at INIT_AREF -> WAIT_MRS; non-NOP/non-AREF -> [0], FAIL.
//    WAIT_MRS: MRS -> RUN, init_done=1 next cycle; other non-NOP -> [0], FAIL.
//    FAIL   : holds until sdram_en falls.
//  - ACT/RD/WR while sdram_en=1 and not RUN -> [6] (not [0]); FSM still goes FAIL.
//  - RUN: refresh timer cleared by AREF, else increments. Reaching T_RFSH_MAX -> [1] once;
//    timer saturates until the next AREF.
//  - TRCAR (all states): any non-NOP within T_RCAR cycles after AREF -> [2].
//    Cycle n+T_RCAR is legal.
//  - Per bank: PRE (a10=1 -> all banks) reloads tRP; ACT while tRP busy -> [3]. ACT reloads tRCD;
//    RD/WR while tRCD busy -> [4]. Gap of exactly T_RP / T_RCD is legal.
//  - CAS: 4-deep expect shift register; RD at n expects rd_valid at n+cfg_cas_lat.
//    Missing or unexpected rd_valid -> [5]. cfg_cas_lat not in {2,3} while RUN -> [7] each cycle.
//  - Simultaneous errors: all bits OR'd; err_cnt +1 per cycle (saturates at all-ones).
//  - err_clr with error same cycle: new bits set, err_cnt=1.
//  - sdram_rst_i mid-sequence: full reset; no error raised.
// STRUCTURE
//  - Package sdram_mon_pkg: sdram_cmd_e, mon_state_e, ERR_* bit indices, decode function.
//  - Sub-module sdram_bank_timer: one bank's tRP/tRCD down-counters and busy flags,
//    instantiated NUM_BANKS times.
// TESTING
//  - Legal init: en rise, 10000 NOP, PRE-all, NOP, AREF, 7 NOP, AREF, 7 NOP, MRS
//    -> init_done=1, err_flags=0.
//  - AREF at cycle 500 of PWRUP -> err_flags=0x01, err_pulse 1 cycle, FSM FAIL, init_done stays 0.
//  - RUN: AREF, then ACT 3 cycles later -> bit2 set, err_cnt=1.
//  - RUN: no AREF for 256 cycles -> bit1 once; err_cnt=1 even at cycle 300.
//  - PRE bank1, ACT bank1 next cycle -> bit3. ACT bank2, RD bank2 +1 -> bit4.
//    RD bank0 at +2 -> no error.
//  - CL=3, RD at n, rd_valid at n+2 only -> bit5 twice (two cycles), err_cnt=2.
//    err_clr -> flags=0, cnt=0.

Source files
------------

// File: rtl/sdram_mon_pkg.sv
// Shared types for the SDRAM command-bus monitor: command/state encodings,
// error bit positions and the command decoder.
package sdram_mon_pkg;

    // Encoding equals {ras_n, cas_n, we_n} so decode is a plain cast.
    typedef enum logic [2:0] {
        CMD_MRS  = 3'b000,
        CMD_AREF = 3'b001,
        CMD_PRE  = 3'b010,
        CMD_ACT  = 3'b011,
        CMD_WR   = 3'b100,
        CMD_RD   = 3'b101,
        CMD_BST  = 3'b110,
        CMD_NOP  = 3'b111
    } sdram_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_WAIT_PRE,
        ST_INIT_AREF,
        ST_WAIT_MRS,
        ST_RUN,
        ST_FAIL
    } mon_state_e;

    localparam int ERR_W               = 8;
    localparam int ERR_INIT_SEQ        = 0;
    localparam int ERR_RFSH_LATE       = 1;
    localparam int ERR_TRCAR           = 2;
    localparam int ERR_TRP             = 3;
    localparam int ERR_TRCD            = 4;
    localparam int ERR_CAS_LAT         = 5;
    localparam int ERR_CMD_BEFORE_INIT = 6;
    localparam int ERR_BAD_CAS_CFG     = 7;

    // Deselected (INHIBIT) is treated exactly like NOP.
    function automatic sdram_cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                              input logic cas_n, input logic we_n);
        if (cs_n)
            return CMD_NOP;
        return sdram_cmd_e'({ras_n, cas_n, we_n});
    endfunction

endpackage

// File: rtl/sdram_bank_timer.sv
// One bank's tRP and tRCD down-counters; busy while a counter is non-zero,
// so a command exactly T_RP / T_RCD cycles after its trigger is legal.
module sdram_bank_timer #(
    parameter int T_RP  = 2,
    parameter int T_RCD = 2,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic srst,
    input  logic pre_hit,
    input  logic act_hit,
    output logic trp_busy,
    output logic trcd_busy
);

    localparam logic [CNT_W-1:0] TRP_LOAD  = CNT_W'((T_RP  > 0) ? T_RP  - 1 : 0);
    localparam logic [CNT_W-1:0] TRCD_LOAD = CNT_W'((T_RCD > 0) ? T_RCD - 1 : 0);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0] trp_cnt_reg;
    logic [CNT_W-1:0] trcd_cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            trp_cnt_reg  <= '0;
            trcd_cnt_reg <= '0;
        end else begin
            if (pre_hit)
                trp_cnt_reg <= TRP_LOAD;
            else if (trp_cnt_reg != '0)
                trp_cnt_reg <= trp_cnt_reg - ONE;

            if (act_hit)
                trcd_cnt_reg <= TRCD_LOAD;
            else if (trcd_cnt_reg != '0)
                trcd_cnt_reg <= trcd_cnt_reg - ONE;
        end
    end

    assign trp_busy  = (trp_cnt_reg  != '0);
    assign trcd_busy = (trcd_cnt_reg != '0);

endmodule

// File: rtl/sdram_cmd_monitor.sv
// SDRAM command-bus protocol monitor: init sequence, refresh interval, tRCAR,
// per-bank tRP/tRCD and CAS-latency read alignment, with sticky error reporting.
module sdram_cmd_monitor
    import sdram_mon_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int T_INIT_NOP = 10000,
    parameter int INIT_AREF  = 2,
    parameter int T_RCAR     = 7,
    parameter int T_RP       = 2,
    parameter int T_RCD      = 2,
    parameter int T_RFSH_MAX = 256,
    parameter int CNT_W      = 16,
    parameter int ERR_CNT_W  = 8,
    localparam int BA_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 sdram_clk,
    input  logic                 sdram_rst_i,
    input  logic                 sdram_en,
    input  logic                 sdram_cs_n,
    input  logic                 sdram_ras_n,
    input  logic                 sdram_cas_n,
    input  logic                 sdram_we_n,
    input  logic [BA_W-1:0]      sdram_ba,
    input  logic                 sdram_a10,
    input  logic [2:0]           cfg_cas_lat,
    input  logic                 rd_valid,
    input  logic                 err_clr,
    output logic                 init_done,
    output logic [7:0]           err_flags,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int AREF_W = (INIT_AREF > 1) ? $clog2(INIT_AREF + 1) : 1;
    localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(T_INIT_NOP - 1);
    localparam logic [CNT_W-1:0]  RFSH_LAST = CNT_W'(T_RFSH_MAX - 1);
    localparam logic [CNT_W-1:0]  RFSH_SAT  = CNT_W'(T_RFSH_MAX);
    localparam logic [CNT_W-1:0]  RCAR_LOAD = CNT_W'((T_RCAR > 0) ? T_RCAR - 1 : 0);
    localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
    localparam logic [AREF_W-1:0] AREF_LAST = AREF_W'(INIT_AREF - 1);

    // Input capture stage: every check works on the registered bus.
    sdram_cmd_e cmd_reg;
    logic [BA_W-1:0] ba_reg;
    logic a10_reg;
    logic en_reg;
    logic rd_valid_reg;
    logic [2:0] cas_lat_reg;

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst_i) begin
            cmd_reg      <= CMD_NOP;
            ba_reg       <= '0;
            a10_reg      <= 1'b0;
            en_reg       <= 1'b0;
            rd_valid_reg <= 1'b0;
            cas_lat_reg  <= 3'd0;
        end else begin
            cmd_reg      <= decode_cmd(sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n);
            ba_reg       <= sdram_ba;
            a10_reg      <= sdram_a10;
            en_reg       <= sdram_en;
            rd_valid_reg <= rd_valid;
            cas_lat_reg  <= cfg_cas_lat;
        end
    end

    mon_state_e state_reg;
    logic [CNT_W-1:0] init_cnt_reg;
    logic [AREF_W-1:0] aref_cnt_reg;
    logic [CNT_W-1:0] rfsh_cnt_reg;
    logic [CNT_W-1:0] rcar_cnt_reg;
    logic [3:0] rd_pipe_reg;
    logic [3:0] rd_pipe_next;

    logic is_nop, is_arw, in_init, run_active, cl_ok, init_bad;
    logic [ERR_W-1:0] err_next;
    logic [NUM_BANKS-1:0] trp_busy;
    logic [NUM_BANKS-1:0] trcd_busy;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            sdram_bank_timer #(
                .T_RP  (T_RP),
                .T_RCD (T_RCD),
                .CNT_W (CNT_W)
            ) u_bank_timer (
                .clk       (sdram_clk),
                .srst      (sdram_rst_i),
                .pre_hit   ((cmd_reg == CMD_PRE) && (a10_reg || (ba_reg == BA_W'(gi)))),
                .act_hit   ((cmd_reg == CMD_ACT) && (ba_reg == BA_W'(gi))),
                .trp_busy  (trp_busy[gi]),
                .trcd_busy (trcd_busy[gi])
            );
        end
    endgenerate

    always_comb begin
        is_nop     = (cmd_reg == CMD_NOP);
        is_arw     = (cmd_reg == CMD_ACT) || (cmd_reg == CMD_RD) || (cmd_reg == CMD_WR);
        in_init    = (state_reg == ST_PWRUP) || (state_reg == ST_WAIT_PRE) ||
                     (state_reg == ST_INIT_AREF) || (state_reg == ST_WAIT_MRS);
        run_active = en_reg && (state_reg == ST_RUN);
        cl_ok      = (cas_lat_reg == 3'd2) || (cas_lat_reg == 3'd3);

        init_bad = 1'b0;
        if (en_reg && in_init && !is_nop) begin
            case (state_reg)
                ST_WAIT_PRE:  init_bad = !((cmd_reg == CMD_PRE) && a10_reg);
                ST_INIT_AREF: init_bad = (cmd_reg != CMD_AREF);
                ST_WAIT_MRS:  init_bad = (cmd_reg != CMD_MRS);
                default:      init_bad = 1'b1;
            endcase
        end

        // Slot k of the pipe holds "rd_valid expected k cycles from now".
        rd_pipe_next = rd_pipe_reg >> 1;
        if ((cmd_reg == CMD_RD) && cl_ok)
            rd_pipe_next[cas_lat_reg[1:0] - 2'd1] = 1'b1;

        err_next = '0;
        err_next[ERR_INIT_SEQ]        = init_bad && !is_arw;
        err_next[ERR_RFSH_LATE]       = run_active && (cmd_reg != CMD_AREF) &&
                                        (rfsh_cnt_reg == RFSH_LAST);
        err_next[ERR_TRCAR]           = !is_nop && (rcar_cnt_reg != '0);
        err_next[ERR_TRP]             = (cmd_reg == CMD_ACT) && trp_busy[ba_reg];
        err_next[ERR_TRCD]            = ((cmd_reg == CMD_RD) || (cmd_reg == CMD_WR)) &&
                                        trcd_busy[ba_reg];
        err_next[ERR_CAS_LAT]         = (rd_valid_reg != rd_pipe_reg[0]);
        err_next[ERR_CMD_BEFORE_INIT] = en_reg && (state_reg != ST_RUN) && is_arw;
        err_next[ERR_BAD_CAS_CFG]     = run_active && !cl_ok;
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst_i) begin
            state_reg    <= ST_IDLE;
            init_cnt_reg <= '0;
            aref_cnt_reg <= '0;
            rfsh_cnt_reg <= '0;
            init_done    <= 1'b0;
        end else if (!en_reg) begin
            state_reg <= ST_IDLE;
            init_done <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    init_cnt_reg <= '0;
                    state_reg    <= is_arw ? ST_FAIL : ST_PWRUP;
                end
                ST_PWRUP: begin
                    if (init_bad)
                        state_reg <= ST_FAIL;
                    else if (init_cnt_reg == INIT_LAST)
                        state_reg <= ST_WAIT_PRE;
                    else
                        init_cnt_reg <= init_cnt_reg + ONE;
                end
                ST_WAIT_PRE: begin
                    aref_cnt_reg <= '0;
                    if (init_bad)
                        state_reg <= ST_FAIL;
                    else if (!is_nop)
                        state_reg <= ST_INIT_AREF;
                end
                ST_INIT_AREF: begin
                    if (init_bad)
                        state_reg <= ST_FAIL;
                    else if (cmd_reg == CMD_AREF) begin
                        if (aref_cnt_reg == AREF_LAST)
                            state_reg <= ST_WAIT_MRS;
                        else
                            aref_cnt_reg <= aref_cnt_reg + AREF_W'(1);
                    end
                end
                ST_WAIT_MRS: begin
                    rfsh_cnt_reg <= '0;
                    if (init_bad)
                        state_reg <= ST_FAIL;
                    else if (cmd_reg == CMD_MRS) begin
                        state_reg <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Saturates one past the limit so the late flag fires only once.
                    if (cmd_reg == CMD_AREF)
                        rfsh_cnt_reg <= '0;
                    else if (rfsh_cnt_reg != RFSH_SAT)
                        rfsh_cnt_reg <= rfsh_cnt_reg + ONE;
                end
                default: state_reg <= ST_FAIL;
            endcase
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst_i) begin
            rcar_cnt_reg <= '0;
            rd_pipe_reg  <= '0;
        end else begin
            if (cmd_reg == CMD_AREF)
                rcar_cnt_reg <= RCAR_LOAD;
            else if (rcar_cnt_reg != '0)
                rcar_cnt_reg <= rcar_cnt_reg - ONE;
            rd_pipe_reg <= rd_pipe_next;
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst_i) begin
            err_flags <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= |err_next;
            if (err_clr) begin
                err_flags <= err_next;
                err_cnt   <= (|err_next) ? ERR_CNT_W'(1) : '0;
            end else begin
                err_flags <= err_flags | err_next;
                if ((|err_next) && (err_cnt != '1))
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Directed bench for sdram_cmd_monitor: legal init, init violations and RUN-time
// timing checks with hand-computed flag/count expectations.
module tb_sdram_cmd_monitor;

    localparam logic [2:0] C_MRS  = 3'b000;
    localparam logic [2:0] C_AREF = 3'b001;
    localparam logic [2:0] C_PRE  = 3'b010;
    localparam logic [2:0] C_ACT  = 3'b011;
    localparam logic [2:0] C_WR   = 3'b100;
    localparam logic [2:0] C_RD   = 3'b101;
    localparam logic [2:0] C_NOP  = 3'b111;

    logic       clk = 1'b0;
    logic       srst;
    logic       en;
    logic       cs_n, ras_n, cas_n, we_n;
    logic [1:0] ba;
    logic       a10;
    logic [2:0] cas_lat;
    logic       rdv;
    logic       clr;
    logic       init_done;
    logic [7:0] err_flags;
    logic       err_pulse;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sdram_cmd_monitor dut (
        .sdram_clk   (clk),
        .sdram_rst_i (srst),
        .sdram_en    (en),
        .sdram_cs_n  (cs_n),
        .sdram_ras_n (ras_n),
        .sdram_cas_n (cas_n),
        .sdram_we_n  (we_n),
        .sdram_ba    (ba),
        .sdram_a10   (a10),
        .cfg_cas_lat (cas_lat),
        .rd_valid    (rdv),
        .err_clr     (clr),
        .init_done   (init_done),
        .err_flags   (err_flags),
        .err_pulse   (err_pulse),
        .err_cnt     (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("[%0t] check %s observed=0x%0h", $time, tag, obs);
    endtask

    // One bus cycle: drive, let the edge sample it, settle 1 time unit after.
    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic a);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = c;
        ba  = b;
        a10 = a;
        @(posedge clk);
        #1;
    endtask

    // Idle cycles are driven as INHIBIT with a garbage opcode underneath.
    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            cs_n = 1'b1;
            {ras_n, cas_n, we_n} = C_MRS;
            ba  = 2'd0;
            a10 = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_errs();
        clr = 1'b1;
        issue(C_NOP, 2'd0, 1'b0);
        clr = 1'b0;
    endtask

    initial begin
        srst = 1'b1; en = 1'b0; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
        ba = 2'd0; a10 = 1'b0; cas_lat = 3'd2; rdv = 1'b0; clr = 1'b0;
        nops(3);
        srst = 1'b0;
        check("reset init_done", 32'(init_done), 32'd0);
        check("reset flags", 32'(err_flags), 32'h00);
        check("reset pulse", 32'(err_pulse), 32'd0);
        check("reset cnt", 32'(err_cnt), 32'd0);

        // Legal init: rise, 10000 idle, PRE-all, NOP, AREF, 7 NOP, AREF, 7 NOP, MRS
        en = 1'b1;
        issue(C_NOP, 2'd0, 1'b0);
        nops(10000);
        issue(C_PRE, 2'd0, 1'b1);
        issue(C_NOP, 2'd0, 1'b0);
        issue(C_AREF, 2'd0, 1'b0);
        nops(7);
        issue(C_AREF, 2'd0, 1'b0);
        nops(7);
        issue(C_MRS, 2'd0, 1'b0);
        nops(2);
        check("init init_done", 32'(init_done), 32'd1);
        check("init flags", 32'(err_flags), 32'h00);
        check("init cnt", 32'(err_cnt), 32'd0);

        // tRCAR: ACT 3 cycles after AREF
        issue(C_AREF, 2'd0, 1'b0);
        nops(2);
        issue(C_ACT, 2'd0, 1'b0);
        issue(C_NOP, 2'd0, 1'b0);
        check("trcar flags", 32'(err_flags), 32'h04);
        check("trcar pulse", 32'(err_pulse), 32'd1);
        check("trcar cnt", 32'(err_cnt), 32'd1);
        issue(C_NOP, 2'd0, 1'b0);
        check("trcar pulse drop", 32'(err_pulse), 32'd0);
        clear_errs();
        check("clr flags", 32'(err_flags), 32'h00);
        check("clr cnt", 32'(err_cnt), 32'd0);

        // tRCAR boundary: ACT exactly T_RCAR after AREF
        nops(4);
        issue(C_AREF, 2'd0, 1'b0);
        nops(6);
        issue(C_ACT, 2'd0, 1'b0);
        issue(C_NOP, 2'd0, 1'b0);
        check("trcar boundary flags", 32'(err_flags), 32'h00);

        // tRP: PRE bank1, ACT bank1 next cycle
        nops(1);
        issue(C_PRE, 2'd1, 1'b0);
        issue(C_ACT, 2'd1, 1'b0);
        issue(C_NOP, 2'd0, 1'b0);
        check("trp flags", 32'(err_flags), 32'h08);
        clear_errs();
        issue(C_PRE, 2'd1, 1'b0);
        issue(C_NOP, 2'd0, 1'b0);
        issue(C_ACT, 2'd1, 1'b0);
        issue(C_NOP, 2'd0, 1'b0);
        check("trp boundary flags", 32'(err_flags), 32'h00);

        // PRE-all covers other banks
        issue(C_PRE, 2'd0, 1'b1);
        issue(C_ACT, 2'd3, 1'b0);
        issue(C_NOP, 2'd0, 1'b0);
        check("trp all-bank flags", 32'(err_flags), 32'h08);
        clear_errs();

        // tRCD: ACT bank2, WR bank2 next cycle
        issue(C_ACT, 2'd2, 1'b0);
        issue(C_WR, 2'd2, 1'b0);
        issue(C_NOP, 2'd0, 1'b0);
        check("trcd flags", 32'(err_flags), 32'h10);
        clear_errs();

        // tRCD boundary and CL=2 aligned read
        issue(C_ACT, 2'd0, 1'b0);
        issue(C_NOP, 2'd0, 1'b0);
        issue(C_RD, 2'd0, 1'b0);
        issue(C_NOP, 2'd0, 1'b0);
        rdv = 1'b1;
        issue(C_NOP, 2'd0, 1'b0);
        rdv = 1'b0;
        nops(2);
        check("trcd boundary cl2 flags", 32'(err_flags), 32'h00);

        // CL=3, data returned one cycle early: unexpected then missing
        cas_lat = 3'd3;
        issue(C_NOP, 2'd0, 1'b0);
        issue(C_RD, 2'd0, 1'b0);
        issue(C_NOP, 2'd0, 1'b0);
        rdv = 1'b1;
        issue(C_NOP, 2'd0, 1'b0);
        rdv = 1'b0;
        nops(3);
        check("cas flags", 32'(err_flags), 32'h20);
        check("cas cnt", 32'(err_cnt), 32'd2);
        cas_lat = 3'd2;
        clear_errs();
        check("cas clr flags", 32'(err_flags), 32'h00);
        check("cas clr cnt", 32'(err_cnt), 32'd0);

        // Simultaneous: PRE then ACT bank1 inside tRCAR window
        issue(C_AREF, 2'd0, 1'b0);
        issue(C_PRE, 2'd1, 1'b0);
        issue(C_ACT, 2'd1, 1'b0);
        issue(C_NOP, 2'd0, 1'b0);
        check("multi flags", 32'(err_flags), 32'h0C);
        check("multi cnt", 32'(err_cnt), 32'd2);
        clear_errs();
        nops(7);

        // Refresh interval: silent at 200 cycles, one error by 300
        issue(C_AREF, 2'd0, 1'b0);
        nops(200);
        check("rfsh early flags", 32'(err_flags), 32'h00);
        nops(100);
        check("rfsh late flags", 32'(err_flags), 32'h02);
        check("rfsh late cnt", 32'(err_cnt), 32'd1);

        // err_clr in the same cycle as a new (bad CAS config) error
        cas_lat = 3'd5;
        issue(C_NOP, 2'd0, 1'b0);
        cas_lat = 3'd2;
        clear_errs();
        check("clr+err flags", 32'(err_flags), 32'h80);
        check("clr+err cnt", 32'(err_cnt), 32'd1);
        clear_errs();

        // Disable then re-init with AREF at PWRUP cycle 500
        en = 1'b0;
        nops(2);
        check("disable init_done", 32'(init_done), 32'd0);
        en = 1'b1;
        issue(C_NOP, 2'd0, 1'b0);
        nops(499);
        issue(C_AREF, 2'd0, 1'b0);
        issue(C_NOP, 2'd0, 1'b0);
        check("pwrup flags", 32'(err_flags), 32'h01);
        check("pwrup pulse", 32'(err_pulse), 32'd1);
        issue(C_NOP, 2'd0, 1'b0);
        check("pwrup pulse drop", 32'(err_pulse), 32'd0);
        check("pwrup init_done", 32'(init_done), 32'd0);

        // ACT while failed and enabled: command-before-init only
        nops(20);
        issue(C_ACT, 2'd0, 1'b0);
        issue(C_NOP, 2'd0, 1'b0);
        check("fail act flags", 32'(err_flags), 32'h41);
        check("fail act cnt", 32'(err_cnt), 32'd2);
        check("fail init_done", 32'(init_done), 32'd0);

        // Reset mid-sequence
        srst = 1'b1;
        issue(C_NOP, 2'd0, 1'b0);
        check("rst flags", 32'(err_flags), 32'h00);
        check("rst cnt", 32'(err_cnt), 32'd0);
        check("rst init_done", 32'(init_done), 32'd0);
        srst = 1'b0;
        nops(3);
        check("post rst flags", 32'(err_flags), 32'h00);
        check("post rst pulse", 32'(err_pulse), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
